rename_table: RTL

- Register alias table and physical-tag free list. Sits directly downstream of the renamer stage and consumes its two per-way queries (source/dest registers, rename request, speculation tag).
- Returns, per way, the physical source tags with ready bits, plus the newly allocated dest tag and the previous dest tag.
- Reports free-tag capacity back to the renamer combinationally, and restores the committed map on flush.

---
 rtl/rename_table.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/rename_table.sv
// rtl/rename_table.sv - register alias table with physical-tag free list
// Purpose: per-way source lookup, destination allocation from a circular free list,
//   writeback ready tracking, in-order commit map, and flush restore to committed state.
// Ports: i_clock/i_reset (async, active-low); i_halt freezes queries; i_flush restores;
//   i_query_* two-way queries; o_* registered per-way results (1-cycle latency);
//   o_ren_capacity combinational min(free_count, 2); i_wb_* ready broadcast;
//   i_commit_* in-order retirement (way 0 older).
// Option: define RENAME_WB_BYPASS_EN so a same-cycle writeback marks a looked-up source ready.
module rename_table #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int TAG_W = $clog2(PHYS_REGS),
  localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS,
  localparam int FW = $clog2(FREE_DEPTH),
  localparam int CW = $clog2(FREE_DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_halt,
  input  logic             i_flush,
  input  logic [AW-1:0]    i_query_rs1      [2],
  input  logic [AW-1:0]    i_query_rs2      [2],
  input  logic [AW-1:0]    i_query_rd       [2],
  input  logic             i_query_rename   [2],
  input  logic             i_query_tag      [2],
  output logic [1:0]       o_ren_capacity,
  output logic [TAG_W-1:0] o_src1_tag       [2],
  output logic [TAG_W-1:0] o_src2_tag       [2],
  output logic             o_src1_rdy       [2],
  output logic             o_src2_rdy       [2],
  output logic [TAG_W-1:0] o_rd_tag         [2],
  output logic [TAG_W-1:0] o_old_rd_tag     [2],
  output logic             o_spec_tag       [2],
  input  logic             i_wb_valid       [2],
  input  logic [TAG_W-1:0] i_wb_tag         [2],
  input  logic             i_commit_valid   [2],
  input  logic [AW-1:0]    i_commit_rd      [2],
  input  logic [TAG_W-1:0] i_commit_tag     [2],
  input  logic [TAG_W-1:0] i_commit_old_tag [2]
);

  logic [TAG_W-1:0]     spec_map_q   [ARCH_REGS];
  logic [TAG_W-1:0]     spec_map_d   [ARCH_REGS];
  logic [TAG_W-1:0]     commit_map_q [ARCH_REGS];
  logic [TAG_W-1:0]     commit_map_d [ARCH_REGS];
  logic [TAG_W-1:0]     fifo_q       [FREE_DEPTH];
  logic [TAG_W-1:0]     fifo_d       [FREE_DEPTH];
  logic [PHYS_REGS-1:0] ready_q, ready_d;
  logic [FW-1:0]        head_q, head_d, commit_head_q, commit_head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;

  logic [TAG_W-1:0] src1_tag_q [2], src1_tag_d [2], src2_tag_q [2], src2_tag_d [2];
  logic [TAG_W-1:0] rd_tag_q [2], rd_tag_d [2], old_tag_q [2], old_tag_d [2];
  logic [1:0]       src1_rdy_q, src1_rdy_d, src2_rdy_q, src2_rdy_d, spec_q, spec_d;

  logic [PHYS_REGS-1:0] wb_vec, byp_vec, fwd_mask;
  logic [1:0]           ren, n_ren, n_push, capacity;
  logic [FW-1:0]        pop_ptr;
  logic [TAG_W-1:0]     s1, s2, new_tag;

  assign capacity       = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
  assign o_ren_capacity = capacity;

  always_comb begin
    wb_vec = '0;
    for (int w = 0; w < 2; w++) begin
      if (i_wb_valid[w] && i_wb_tag[w] != '0) wb_vec[i_wb_tag[w]] = 1'b1;
    end
  end

`ifdef RENAME_WB_BYPASS_EN
  assign byp_vec = wb_vec;
`else
  assign byp_vec = '0;
`endif

  always_comb begin
    spec_map_d    = spec_map_q;
    commit_map_d  = commit_map_q;
    fifo_d        = fifo_q;
    head_d        = head_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    src1_tag_d    = src1_tag_q;
    src2_tag_d    = src2_tag_q;
    rd_tag_d      = rd_tag_q;
    old_tag_d     = old_tag_q;
    src1_rdy_d    = src1_rdy_q;
    src2_rdy_d    = src2_rdy_q;
    spec_d        = spec_q;
    n_push        = '0;
    fwd_mask      = '0;
    pop_ptr       = head_q;
    s1            = '0;
    s2            = '0;
    new_tag       = '0;

    // Commits land first so a same-cycle flush restores from the updated map.
    for (int w = 0; w < 2; w++) begin
      if (i_commit_valid[w] && i_commit_rd[w] != '0) begin
        commit_map_d[i_commit_rd[w]] = i_commit_tag[w];
        fifo_d[tail_d] = i_commit_old_tag[w];
        tail_d         = tail_d + FW'(1);
        commit_head_d  = commit_head_d + FW'(1);
        n_push         = n_push + 2'd1;
      end
    end

    ready_d = ready_q | wb_vec;
    for (int w = 0; w < 2; w++) ren[w] = i_query_rename[w] && (i_query_rd[w] != '0);
    n_ren = {1'b0, ren[0]} + {1'b0, ren[1]};

    if (i_flush) begin
      spec_map_d = commit_map_d;
      head_d     = commit_head_d;
      // The committed image always owns exactly FREE_DEPTH free tags.
      count_d    = CW'(FREE_DEPTH);
      for (int r = 0; r < ARCH_REGS; r++) ready_d[commit_map_d[r]] = 1'b1;
      for (int w = 0; w < 2; w++) begin
        src1_tag_d[w] = '0;
        src2_tag_d[w] = '0;
        rd_tag_d[w]   = '0;
        old_tag_d[w]  = '0;
      end
      src1_rdy_d = '0;
      src2_rdy_d = '0;
      spec_d     = '0;
    end else begin
      count_d = count_q + CW'(n_push);
      if (!i_halt) begin
        for (int w = 0; w < 2; w++) spec_d[w] = i_query_tag[w];
        if (n_ren > capacity) begin
          for (int w = 0; w < 2; w++) begin
            src1_tag_d[w] = '0;
            src2_tag_d[w] = '0;
            rd_tag_d[w]   = '0;
            old_tag_d[w]  = '0;
          end
          src1_rdy_d = '0;
          src2_rdy_d = '0;
        end else begin
          // Ways resolve in order; way 1 reads spec_map_d so it sees way 0's rename,
          // and fwd_mask keeps a tag allocated earlier in the group not-ready.
          for (int w = 0; w < 2; w++) begin
            s1            = spec_map_d[i_query_rs1[w]];
            s2            = spec_map_d[i_query_rs2[w]];
            src1_tag_d[w] = s1;
            src2_tag_d[w] = s2;
            src1_rdy_d[w] = ~fwd_mask[s1] & (ready_q[s1] | byp_vec[s1]);
            src2_rdy_d[w] = ~fwd_mask[s2] & (ready_q[s2] | byp_vec[s2]);
            old_tag_d[w]  = spec_map_d[i_query_rd[w]];
            if (ren[w]) begin
              new_tag                    = fifo_q[pop_ptr];
              pop_ptr                    = pop_ptr + FW'(1);
              rd_tag_d[w]                = new_tag;
              spec_map_d[i_query_rd[w]]  = new_tag;
              ready_d[new_tag]           = 1'b0;
              fwd_mask[new_tag]          = 1'b1;
            end else begin
              rd_tag_d[w] = spec_map_d[i_query_rd[w]];
            end
          end
          head_d  = pop_ptr;
          count_d = count_q + CW'(n_push) - CW'(n_ren);
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map_q[i]   <= TAG_W'(i);
        commit_map_q[i] <= TAG_W'(i);
      end
      for (int i = 0; i < FREE_DEPTH; i++) fifo_q[i] <= TAG_W'(ARCH_REGS + i);
      ready_q       <= '1;
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      count_q       <= CW'(FREE_DEPTH);
      for (int w = 0; w < 2; w++) begin
        src1_tag_q[w] <= '0;
        src2_tag_q[w] <= '0;
        rd_tag_q[w]   <= '0;
        old_tag_q[w]  <= '0;
      end
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      spec_q     <= '0;
    end else begin
      spec_map_q    <= spec_map_d;
      commit_map_q  <= commit_map_d;
      fifo_q        <= fifo_d;
      ready_q       <= ready_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      src1_tag_q    <= src1_tag_d;
      src2_tag_q    <= src2_tag_d;
      rd_tag_q      <= rd_tag_d;
      old_tag_q     <= old_tag_d;
      src1_rdy_q    <= src1_rdy_d;
      src2_rdy_q    <= src2_rdy_d;
      spec_q        <= spec_d;
    end
  end

  for (genvar w = 0; w < 2; w++) begin : g_out
    assign o_src1_tag[w]   = src1_tag_q[w];
    assign o_src2_tag[w]   = src2_tag_q[w];
    assign o_src1_rdy[w]   = src1_rdy_q[w];
    assign o_src2_rdy[w]   = src2_rdy_q[w];
    assign o_rd_tag[w]     = rd_tag_q[w];
    assign o_old_rd_tag[w] = old_tag_q[w];
    assign o_spec_tag[w]   = spec_q[w];
  end

endmodule
